// File: rtl/cpu_pkg.sv
// Shared definitions for the sequential datapath: ALU opcodes, sequencer
// state type and opcode-class helpers.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_SHL  = 4'd4,
        ALU_SHR  = 4'd5,
        ALU_SHRA = 4'd6,
        ALU_ROL  = 4'd7,
        ALU_ROR  = 4'd8,
        ALU_NEG  = 4'd9,
        ALU_NOT  = 4'd10,
        ALU_MUL  = 4'd11,
        ALU_DIV  = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } seq_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

    function automatic logic is_single(input logic [3:0] op);
        return op <= ALU_NOT;
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle signed multiply (radix-2 Booth) and signed restoring divide,
// one iteration per clock, result presented to Z during FINISH.
module muldiv_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic             res_wr,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    seq_state_e              state, nxt;
    logic [CNT_W-1:0]        cnt;
    logic                    accept, div_zero, op_div, quo_neg, rem_neg;
    logic signed [WIDTH:0]   acc, mcand, sum, shifted, diff, acc_nx;
    logic [WIDTH-1:0]        qr, qr_nx;
    logic                    q_m1;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return (v < 0) ? -v : v;
    endfunction

    assign accept   = start && (state == IDLE) && is_muldiv(op);
    assign div_zero = (op == ALU_DIV) && (b == '0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt    = state;
        busy   = 1'b0;
        res_wr = 1'b0;
        case (state)
            IDLE: if (accept) nxt = div_zero ? FINISH : RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) nxt = FINISH;
            end
            FINISH: begin
                busy   = 1'b1;
                res_wr = 1'b1;
                nxt    = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt     <= '0;
            done    <= 1'b0;
            div0    <= 1'b0;
            op_div  <= 1'b0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else begin
            done <= (state == FINISH);
            if (accept) begin
                cnt     <= '0;
                div0    <= div_zero;
                op_div  <= (op == ALU_DIV);
                quo_neg <= a[WIDTH-1] ^ b[WIDTH-1];
                rem_neg <= a[WIDTH-1];
            end else if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Divide works on magnitudes; signs are restored when the result is presented.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc  <= '0;
            q_m1 <= 1'b0;
            if (op == ALU_DIV) begin
                mcand <= {1'b0, mag(b)};
                qr    <= div_zero ? a : mag(a);
            end else begin
                mcand <= {a[WIDTH-1], a};
                qr    <= b;
            end
        end else if (state == RUN) begin
            acc  <= acc_nx;
            qr   <= qr_nx;
            q_m1 <= qr[0];
        end
    end

    always_comb begin
        sum     = acc;
        shifted = '0;
        diff    = '0;
        acc_nx  = acc;
        qr_nx   = qr;
        if (op_div) begin
            shifted = {acc[WIDTH-1:0], qr[WIDTH-1]};
            diff    = shifted - mcand;
            if (diff[WIDTH]) begin
                acc_nx = shifted;
                qr_nx  = {qr[WIDTH-2:0], 1'b0};
            end else begin
                acc_nx = diff;
                qr_nx  = {qr[WIDTH-2:0], 1'b1};
            end
        end else begin
            case ({qr[0], q_m1})
                2'b01:   sum = acc + mcand;
                2'b10:   sum = acc - mcand;
                default: sum = acc;
            endcase
            acc_nx = sum >>> 1;
            qr_nx  = {sum[0], qr[WIDTH-1:1]};
        end
    end

    always_comb begin
        res_hi = acc[WIDTH-1:0];
        res_lo = qr;
        if (op_div) begin
            if (div0) begin
                res_hi = qr;
                res_lo = '1;
            end else begin
                res_lo = quo_neg ? -qr : qr;
                res_hi = rem_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/seq_datapath.sv
// Single-bus datapath: general registers, PC/IR/MAR/MDR, Y, HI/LO, Z,
// single-cycle ALU and a multi-cycle MUL/DIV sequencer.
module seq_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16,
    parameter int PC_STEP  = 1
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        gp_in,
    input  logic                        gp_out,
    input  logic [$clog2(NUM_REGS)-1:0] gp_wsel,
    input  logic [$clog2(NUM_REGS)-1:0] gp_rsel,
    input  logic                        pc_in,
    input  logic                        inc_pc,
    input  logic                        pc_out,
    input  logic                        ir_in,
    input  logic                        mar_in,
    input  logic                        y_in,
    input  logic                        hi_in,
    input  logic                        lo_in,
    input  logic                        hi_out,
    input  logic                        lo_out,
    input  logic                        mdr_in,
    input  logic                        mdr_out,
    input  logic                        read,
    input  logic                        z_in,
    input  logic                        zlo_out,
    input  logic                        zhi_out,
    input  logic                        c_out,
    input  logic [WIDTH-1:0]            c_data,
    input  logic [3:0]                  alu_op,
    input  logic                        start,
    input  logic [WIDTH-1:0]            mdata_in,
    output logic [WIDTH-1:0]            bus_q,
    output logic [WIDTH-1:0]            ir_q,
    output logic [WIDTH-1:0]            mar_q,
    output logic [WIDTH-1:0]            mdr_q,
    output logic                        busy,
    output logic                        done,
    output logic                        div0,
    output logic                        bus_err
);

    logic [WIDTH-1:0]        gpr [NUM_REGS];
    logic [WIDTH-1:0]        pc, ir, mar, mdr, y, hi, lo, zhi, zlo;
    logic [WIDTH-1:0]        bus, shamt, alu_res, seq_hi, seq_lo;
    logic signed [WIDTH-1:0] y_s;
    logic [7:0]              drv;
    logic                    multi_drv, seq_wr;

    assign drv       = {gp_out, pc_out, mdr_out, hi_out, lo_out, zlo_out, zhi_out, c_out};
    assign multi_drv = $countones(drv) > 1;

    // Contention forces the bus to zero rather than OR-ing sources together.
    always_comb begin
        bus = '0;
        if (!multi_drv) begin
            if (gp_out)  bus = gpr[gp_rsel];
            if (pc_out)  bus = pc;
            if (mdr_out) bus = mdr;
            if (hi_out)  bus = hi;
            if (lo_out)  bus = lo;
            if (zlo_out) bus = zlo;
            if (zhi_out) bus = zhi;
            if (c_out)   bus = c_data;
        end
    end

    assign y_s   = y;
    assign shamt = bus % WIDTH'(WIDTH);

    always_comb begin
        case (alu_op)
            ALU_ADD:  alu_res = y + bus;
            ALU_SUB:  alu_res = y - bus;
            ALU_AND:  alu_res = y & bus;
            ALU_OR:   alu_res = y | bus;
            ALU_SHL:  alu_res = y << shamt;
            ALU_SHR:  alu_res = y >> shamt;
            ALU_SHRA: alu_res = y_s >>> shamt;
            ALU_ROL:  alu_res = (y << shamt) | (y >> (WIDTH'(WIDTH) - shamt));
            ALU_ROR:  alu_res = (y >> shamt) | (y << (WIDTH'(WIDTH) - shamt));
            ALU_NEG:  alu_res = -bus;
            ALU_NOT:  alu_res = ~bus;
            default:  alu_res = '0;
        endcase
    end

    muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .op     (alu_op),
        .a      (y),
        .b      (bus),
        .busy   (busy),
        .done   (done),
        .div0   (div0),
        .res_wr (seq_wr),
        .res_hi (seq_hi),
        .res_lo (seq_lo)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
            pc      <= '0;
            ir      <= '0;
            mar     <= '0;
            mdr     <= '0;
            y       <= '0;
            hi      <= '0;
            lo      <= '0;
            zhi     <= '0;
            zlo     <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= bus_err | multi_drv;
            if (gp_in)       gpr[gp_wsel] <= bus;
            if (pc_in)       pc <= bus;
            else if (inc_pc) pc <= pc + WIDTH'(PC_STEP);
            if (ir_in)       ir  <= bus;
            if (mar_in)      mar <= bus;
            if (y_in)        y   <= bus;
            if (hi_in)       hi  <= bus;
            if (lo_in)       lo  <= bus;
            if (mdr_in)      mdr <= read ? mdata_in : bus;
            if (seq_wr) begin
                zhi <= seq_hi;
                zlo <= seq_lo;
            end else if (z_in && !busy && is_single(alu_op)) begin
                zhi <= '0;
                zlo <= alu_res;
            end
        end
    end

    assign bus_q = bus;
    assign ir_q  = ir;
    assign mar_q = mar;
    assign mdr_q = mdr;

endmodule

// File: tb/tb_seq_datapath.sv
// Directed plus randomized bench for seq_datapath with a behavioural model.
module tb_seq_datapath;
    import cpu_pkg::*;

    localparam int W = 32;

    logic          clk, clr;
    logic          gp_in, gp_out, pc_in, inc_pc, pc_out, ir_in, mar_in, y_in;
    logic          hi_in, lo_in, hi_out, lo_out, mdr_in, mdr_out, read;
    logic          z_in, zlo_out, zhi_out, c_out, start;
    logic [3:0]    gp_wsel, gp_rsel, alu_op;
    logic [W-1:0]  c_data, mdata_in, bus_q, ir_q, mar_q, mdr_q;
    logic          busy, done, div0, bus_err;

    int n_cmp = 0;
    int n_err = 0;

    seq_datapath #(.WIDTH(W), .NUM_REGS(16), .PC_STEP(1)) dut (
        .clk(clk), .clr(clr), .gp_in(gp_in), .gp_out(gp_out), .gp_wsel(gp_wsel), .gp_rsel(gp_rsel),
        .pc_in(pc_in), .inc_pc(inc_pc), .pc_out(pc_out), .ir_in(ir_in), .mar_in(mar_in), .y_in(y_in),
        .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out), .mdr_in(mdr_in),
        .mdr_out(mdr_out), .read(read), .z_in(z_in), .zlo_out(zlo_out), .zhi_out(zhi_out),
        .c_out(c_out), .c_data(c_data), .alu_op(alu_op), .start(start), .mdata_in(mdata_in),
        .bus_q(bus_q), .ir_q(ir_q), .mar_q(mar_q), .mdr_q(mdr_q), .busy(busy), .done(done),
        .div0(div0), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctl();
        {gp_in, gp_out, pc_in, inc_pc, pc_out, ir_in, mar_in, y_in} = '0;
        {hi_in, lo_in, hi_out, lo_out, mdr_in, mdr_out, read} = '0;
        {z_in, zlo_out, zhi_out, c_out, start} = '0;
        c_data = '0;
    endtask

    task automatic read_z(output logic [W-1:0] lo, output logic [W-1:0] hi);
        zlo_out = 1'b1; #1; lo = bus_q; zlo_out = 1'b0;
        zhi_out = 1'b1; #1; hi = bus_q; zhi_out = 1'b0;
    endtask

    task automatic set_y(input logic [W-1:0] v);
        idle_ctl();
        c_out = 1'b1; c_data = v; y_in = 1'b1;
        step();
        idle_ctl();
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        int n;
        n = int'(b % 32);
        r = a;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_SHL:  repeat (n) r = {r[W-2:0], 1'b0};
            ALU_SHR:  repeat (n) r = {1'b0, r[W-1:1]};
            ALU_SHRA: repeat (n) r = {r[W-1], r[W-1:1]};
            ALU_ROL:  repeat (n) r = {r[W-2:0], r[W-1]};
            ALU_ROR:  repeat (n) r = {r[0], r[W-1:1]};
            ALU_NEG:  r = 32'd0 - b;
            ALU_NOT:  r = ~b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Returns {hi, lo} as Z should hold it after the operation.
    function automatic logic [63:0] ref_muldiv(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa, sb, q, r, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == ALU_MUL) begin
            p = sa * sb;
            return p;
        end
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_single(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] lo, hi;
        set_y(a);
        c_out = 1'b1; c_data = b; alu_op = op; z_in = 1'b1;
        step();
        idle_ctl();
        read_z(lo, hi);
        check($sformatf("alu op%0d a=%h b=%h zlo", op, a, b), lo, ref_alu(op, a, b));
        check($sformatf("alu op%0d zhi", op), hi, 0);
    endtask

    task automatic run_muldiv(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input bit disturb);
        logic [W-1:0] lo, hi;
        logic [63:0]  exp;
        int cyc;
        bit zero_div;
        zero_div = (op == ALU_DIV) && (b == 0);
        exp = ref_muldiv(op, a, b);
        set_y(a);
        c_out = 1'b1; c_data = b; alu_op = op; start = 1'b1;
        step();
        idle_ctl();
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (disturb && cyc == 5) begin
                start = 1'b1; alu_op = ALU_MUL; c_out = 1'b1; c_data = 32'h1234;
            end else if (disturb && cyc == 6) begin
                start = 1'b0; alu_op = ALU_ADD; z_in = 1'b1;
                c_out = 1'b1; c_data = 32'h55; gp_in = 1'b1; gp_wsel = 4'd7;
            end else begin
                idle_ctl();
            end
            step();
        end
        idle_ctl();
        check($sformatf("op%0d busy cycles", op), cyc, zero_div ? 1 : 33);
        check($sformatf("op%0d done pulse", op), done, 1);
        check($sformatf("op%0d div0", op), div0, zero_div);
        step();
        check($sformatf("op%0d done one cycle", op), done, 0);
        read_z(lo, hi);
        check($sformatf("op%0d a=%h b=%h zlo", op, a, b), lo, exp[31:0]);
        check($sformatf("op%0d a=%h b=%h zhi", op, a, b), hi, exp[63:32]);
        if (disturb) begin
            gp_out = 1'b1; gp_rsel = 4'd7; #1;
            check("gp load while busy", bus_q, 32'h55);
            gp_out = 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0] lo, hi, ra, rb;
        logic [3:0]   op;
        int           done_seen;

        idle_ctl();
        clr = 1'b0; gp_wsel = '0; gp_rsel = '0; alu_op = ALU_ADD; mdata_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset bus", bus_q, 0);
        check("reset ir", ir_q, 0);
        check("reset mar", mar_q, 0);
        check("reset mdr", mdr_q, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div0", div0, 0);
        check("reset bus_err", bus_err, 0);
        clr = 1'b1;
        step();

        // R3 <= 5, Y <= R3, ADD with 7.
        c_out = 1'b1; c_data = 32'h5; gp_in = 1'b1; gp_wsel = 4'd3;
        step(); idle_ctl();
        gp_out = 1'b1; gp_rsel = 4'd3; y_in = 1'b1;
        step(); idle_ctl();
        c_out = 1'b1; c_data = 32'h7; alu_op = ALU_ADD; z_in = 1'b1;
        step(); idle_ctl();
        read_z(lo, hi);
        check("add zlo", lo, 32'hC);
        check("add zhi", hi, 0);

        c_out = 1'b1; c_data = 32'hA5A5_1234; ir_in = 1'b1; mar_in = 1'b1;
        step(); idle_ctl();
        check("ir load", ir_q, 32'hA5A5_1234);
        check("mar load", mar_q, 32'hA5A5_1234);
        mdr_in = 1'b1; read = 1'b1; mdata_in = 32'hDEAD_BEEF; c_out = 1'b1; c_data = 32'h1;
        step(); idle_ctl();
        check("mdr from memory", mdr_q, 32'hDEAD_BEEF);
        mdr_in = 1'b1; c_out = 1'b1; c_data = 32'h1357;
        step(); idle_ctl();
        check("mdr from bus", mdr_q, 32'h1357);
        mdr_out = 1'b1; #1;
        check("mdr drive", bus_q, 32'h1357);
        idle_ctl();
        c_out = 1'b1; c_data = 32'h1111_2222; hi_in = 1'b1;
        step(); idle_ctl();
        c_out = 1'b1; c_data = 32'h3333_4444; lo_in = 1'b1;
        step(); idle_ctl();
        hi_out = 1'b1; #1;
        check("hi drive", bus_q, 32'h1111_2222);
        hi_out = 1'b0; lo_out = 1'b1; #1;
        check("lo drive", bus_q, 32'h3333_4444);
        idle_ctl(); #1;
        check("undriven bus", bus_q, 0);

        c_out = 1'b1; c_data = 32'hFFFF_FFFF; pc_in = 1'b1;
        step(); idle_ctl();
        inc_pc = 1'b1;
        step(); idle_ctl();
        pc_out = 1'b1; #1;
        check("pc wrap", bus_q, 0);
        idle_ctl();
        c_out = 1'b1; c_data = 32'h100; pc_in = 1'b1; inc_pc = 1'b1;
        step(); idle_ctl();
        pc_out = 1'b1; #1;
        check("pc_in priority", bus_q, 32'h100);
        idle_ctl();
        inc_pc = 1'b1;
        step(); idle_ctl();
        pc_out = 1'b1; #1;
        check("pc increment", bus_q, 32'h101);
        idle_ctl();

        run_single(ALU_SHL, 32'h8000_0001, 32'd32);
        run_single(ALU_ROR, 32'h0000_00F1, 32'd33);
        run_single(ALU_SHRA, 32'h8000_0000, 32'd31);
        for (int i = 0; i < 12; i++) begin
            op = 4'($urandom_range(0, 10));
            ra = $urandom;
            rb = $urandom;
            run_single(op, ra, rb);
        end

        alu_op = ALU_ADD; start = 1'b1;
        step(); idle_ctl();
        check("start with single-cycle op ignored", busy, 0);

        run_muldiv(ALU_MUL, 32'hFFFF_FFFE, 32'h3, 1'b1);
        run_muldiv(ALU_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0);
        run_muldiv(ALU_DIV, 32'hFFFF_FFF9, 32'h0, 1'b0);
        run_muldiv(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_muldiv(ALU_MUL, 32'h8000_0000, 32'h8000_0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_muldiv(ALU_MUL, $urandom, $urandom, 1'b0);
            run_muldiv(ALU_DIV, $urandom, $urandom >> $urandom_range(0, 31), 1'b0);
        end

        gp_out = 1'b1; gp_rsel = 4'd3; pc_out = 1'b1; #1;
        check("contention bus", bus_q, 0);
        check("bus_err before edge", bus_err, 0);
        step(); idle_ctl();
        check("bus_err set", bus_err, 1);
        step(); step();
        check("bus_err sticky", bus_err, 1);

        set_y($urandom);
        c_out = 1'b1; c_data = $urandom | 32'h1; alu_op = ALU_MUL; start = 1'b1;
        step(); idle_ctl();
        repeat (9) step();
        check("busy before abort", busy, 1);
        clr = 1'b0; #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort bus_err", bus_err, 0);
        read_z(lo, hi);
        check("abort zlo", lo, 0);
        check("abort zhi", hi, 0);
        clr = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("no activity after abort", done_seen, 0);
        run_muldiv(ALU_MUL, $urandom, $urandom, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
